// File: rtl/psum_collector.sv
// psum_collector: column-bottom consumer for the systolic PE array.
// Captures the psum stream leaving the last PE of a column, accumulates it
// across K-tile passes in a DEPTH-entry buffer, then drains the finished
// sums through a valid/ready port once the final pass has completed.
// Optional feature macro: PSUM_COLLECTOR_SAT_EN selects a signed saturating
// accumulate; without it the accumulate wraps around in two's complement.
module psum_collector #(
    parameter int PSUM_WIDTH     = 32,
    parameter int DEPTH          = 8,
    parameter int PASS_CNT_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [PSUM_WIDTH-1:0]     psum_i,
    input  logic                      psum_en_i,
    input  logic                      tile_last_i,
    input  logic                      clear_i,
    output logic [PSUM_WIDTH-1:0]     out_data_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic                      out_last_o,
    output logic                      busy_o,
    output logic                      overflow_o,
    output logic [PASS_CNT_WIDTH-1:0] pass_cnt_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          widx_q, widx_d;
    logic [IDX_W-1:0]          ridx_q, ridx_d;
    logic                      first_q, first_d;
    logic                      last_pass_q, last_pass_d;
    logic                      overflow_q, overflow_d;
    logic [PASS_CNT_WIDTH-1:0] pass_cnt_q, pass_cnt_d;

    logic [PSUM_WIDTH-1:0]     mem_q [DEPTH];
    logic                      wr_en;
    logic [IDX_W-1:0]          wr_idx;
    logic [PSUM_WIDTH-1:0]     wr_val;

    // Accumulate one psum onto a stored partial sum.
    function automatic logic [PSUM_WIDTH-1:0] acc_add(
        input logic [PSUM_WIDTH-1:0] a,
        input logic [PSUM_WIDTH-1:0] b
    );
        logic [PSUM_WIDTH-1:0] sum;
        sum = a + b;
`ifdef PSUM_COLLECTOR_SAT_EN
        // Same-sign operands producing an opposite-sign result overflowed.
        if ((a[PSUM_WIDTH-1] == b[PSUM_WIDTH-1]) && (sum[PSUM_WIDTH-1] != a[PSUM_WIDTH-1])) begin
            sum = a[PSUM_WIDTH-1] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                  : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
        end
`endif
        return sum;
    endfunction

    // Next-state logic: clear wins over everything, then per-state behaviour.
    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        ridx_d      = ridx_q;
        first_d     = first_q;
        last_pass_d = last_pass_q;
        overflow_d  = overflow_q;
        pass_cnt_d  = pass_cnt_q;
        wr_en       = 1'b0;

        if (clear_i) begin
            state_d    = ST_IDLE;
            widx_d     = '0;
            ridx_d     = '0;
            first_d    = 1'b1;
            overflow_d = 1'b0;
            pass_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (psum_en_i) begin
                        wr_en       = 1'b1;
                        last_pass_d = tile_last_i;
                        widx_d      = IDX_W'(1);
                        state_d     = ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (psum_en_i) begin
                        wr_en = 1'b1;
                        if (widx_q == LAST_IDX) begin
                            widx_d     = '0;
                            pass_cnt_d = pass_cnt_q + PASS_CNT_WIDTH'(1);
                            if (last_pass_q) begin
                                state_d = ST_DRAIN;
                                ridx_d  = '0;
                            end else begin
                                state_d = ST_IDLE;
                                first_d = 1'b0;
                            end
                        end else begin
                            widx_d = widx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (psum_en_i) begin
                        overflow_d = 1'b1;
                    end
                    if (out_ready_i) begin
                        if (ridx_q == LAST_IDX) begin
                            state_d    = ST_IDLE;
                            ridx_d     = '0;
                            first_d    = 1'b1;
                            pass_cnt_d = '0;
                        end else begin
                            ridx_d = ridx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Buffer write port: the first pass overwrites, later passes accumulate.
    always_comb begin
        wr_idx = (state_q == ST_ACCUM) ? widx_q : '0;
        wr_val = first_q ? psum_i : acc_add(mem_q[wr_idx], psum_i);
    end

    // Control registers, abandoned asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            widx_q      <= '0;
            ridx_q      <= '0;
            first_q     <= 1'b1;
            last_pass_q <= 1'b0;
            overflow_q  <= 1'b0;
            pass_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            ridx_q      <= ridx_d;
            first_q     <= first_d;
            last_pass_q <= last_pass_d;
            overflow_q  <= overflow_d;
            pass_cnt_q  <= pass_cnt_d;
        end
    end

    // Buffer storage; stale contents are harmless because of the first flag.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_val;
        end
    end

    // Output decode: data reads zero whenever no result is being offered.
    always_comb begin
        out_valid_o = (state_q == ST_DRAIN);
        out_data_o  = out_valid_o ? mem_q[ridx_q] : '0;
        out_last_o  = out_valid_o && (ridx_q == LAST_IDX);
        busy_o      = (state_q != ST_IDLE);
        overflow_o  = overflow_q;
        pass_cnt_o  = pass_cnt_q;
    end

endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed bench for psum_collector (DEPTH=4, 32-bit).
// A transaction-level model (accumulator array plus a queue of results
// awaiting drain) predicts every output each cycle; literal expectations
// pin the model on the scenarios of interest.
module tb_psum_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] psum_i = '0;
    logic        psum_en_i = 1'b0;
    logic        tile_last_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic        out_valid_o;
    logic        out_last_o;
    logic        busy_o;
    logic        overflow_o;
    logic [3:0]  pass_cnt_o;

    int checks = 0;
    int failures = 0;

    // Behavioural model state.
    logic [31:0] m_acc [4];
    bit          m_fresh = 1'b1;
    int          m_cnt = 0;
    bit          m_last = 1'b0;
    logic [3:0]  m_pass = '0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_q [$];

    // Values actually accepted from the DUT output port.
    logic [31:0] got_q [$];

    psum_collector #(
        .PSUM_WIDTH(32),
        .DEPTH(4),
        .PASS_CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .psum_i(psum_i),
        .psum_en_i(psum_en_i),
        .tile_last_i(tile_last_i),
        .clear_i(clear_i),
        .out_data_o(out_data_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_last_o(out_last_o),
        .busy_o(busy_o),
        .overflow_o(overflow_o),
        .pass_cnt_o(pass_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
`ifdef PSUM_COLLECTOR_SAT_EN
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647) return 32'h7FFFFFFF;
        if (s < -64'sd2147483648) return 32'h80000000;
        return 32'(s);
`else
        return a + b;
`endif
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_pass(input logic [31:0] v [4], input bit last);
        for (int i = 0; i < 4; i++) begin
            psum_en_i   = 1'b1;
            psum_i      = v[i];
            tile_last_i = last;
            step();
        end
        psum_en_i   = 1'b0;
        tile_last_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 100) begin
            step();
            n++;
        end
        check_output("drain_timeout_busy", 32'(busy_o), 32'd0);
    endtask

    task automatic check_got(input string name, input logic [31:0] exp [4]);
        check_output({name, "_count"}, 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            check_output($sformatf("%s_%0d", name, i), got_q[i], exp[i]);
        end
    endtask

    task automatic check_all_zero(input string name);
        check_output({name, "_valid"}, 32'(out_valid_o), 32'd0);
        check_output({name, "_data"}, out_data_o, 32'd0);
        check_output({name, "_last"}, 32'(out_last_o), 32'd0);
        check_output({name, "_busy"}, 32'(busy_o), 32'd0);
        check_output({name, "_overflow"}, 32'(overflow_o), 32'd0);
        check_output({name, "_pass_cnt"}, 32'(pass_cnt_o), 32'd0);
    endtask

    // Model update: one step of the transaction-level rules per clock edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_fresh = 1'b1;
                m_cnt   = 0;
                m_pass  = '0;
                m_ovf   = 1'b0;
                m_q.delete();
            end else if (clear_i) begin
                m_fresh = 1'b1;
                m_cnt   = 0;
                m_pass  = '0;
                m_ovf   = 1'b0;
                m_q.delete();
            end else if (m_q.size() > 0) begin
                if (psum_en_i) m_ovf = 1'b1;
                if (out_ready_i) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) begin
                        m_fresh = 1'b1;
                        m_pass  = '0;
                    end
                end
            end else if (psum_en_i) begin
                if (m_cnt == 0) m_last = tile_last_i;
                m_acc[m_cnt] = m_fresh ? psum_i : model_add(m_acc[m_cnt], psum_i);
                m_cnt++;
                if (m_cnt == 4) begin
                    m_cnt  = 0;
                    m_pass = m_pass + 4'd1;
                    if (m_last) begin
                        for (int i = 0; i < 4; i++) m_q.push_back(m_acc[i]);
                    end else begin
                        m_fresh = 1'b0;
                    end
                end
            end
        end
    end

    // Compare process: every output against the model, mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            check_output("valid", 32'(out_valid_o), 32'(m_q.size() > 0));
            check_output("data", out_data_o, (m_q.size() > 0) ? m_q[0] : 32'd0);
            check_output("last", 32'(out_last_o), 32'(m_q.size() == 1));
            check_output("busy", 32'(busy_o), 32'((m_cnt > 0) || (m_q.size() > 0)));
            check_output("overflow", 32'(overflow_o), 32'(m_ovf));
            check_output("pass_cnt", 32'(pass_cnt_o), 32'(m_pass));
            if (rst_n && out_valid_o && out_ready_i) got_q.push_back(out_data_o);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        bit pat [8];
        logic [31:0] exp_arith [4];
        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        #2;
        check_all_zero("reset");
        #2 rst_n = 1'b1;
        step();

        $display("[TB] single pass");
        got_q.delete();
        out_ready_i = 1'b1;
        apply_pass('{32'd1, 32'd2, 32'd3, 32'd4}, 1'b1);
        check_output("single_valid_rise", 32'(out_valid_o), 32'd1);
        check_output("single_first_data", out_data_o, 32'd1);
        wait_idle();
        check_got("single", '{32'd1, 32'd2, 32'd3, 32'd4});

        $display("[TB] two passes");
        got_q.delete();
        apply_pass('{32'd10, 32'd20, 32'd30, 32'd40}, 1'b0);
        check_output("two_pass_cnt1", 32'(pass_cnt_o), 32'd1);
        check_output("two_pass_busy_gap", 32'(busy_o), 32'd0);
        step();
        step();
        apply_pass('{32'd1, 32'd2, 32'd3, 32'd4}, 1'b1);
        check_output("two_pass_cnt2", 32'(pass_cnt_o), 32'd2);
        wait_idle();
        check_got("two_pass", '{32'd11, 32'd22, 32'd33, 32'd44});
        check_output("two_pass_cnt_zero", 32'(pass_cnt_o), 32'd0);

        $display("[TB] backpressure");
        got_q.delete();
        out_ready_i = 1'b0;
        apply_pass('{32'd100, 32'd200, 32'd300, 32'd400}, 1'b1);
        for (int i = 0; i < 8; i++) begin
            out_ready_i = pat[i];
            step();
        end
        check_output("bp_done_busy", 32'(busy_o), 32'd0);
        out_ready_i = 1'b1;
        wait_idle();
        check_got("bp", '{32'd100, 32'd200, 32'd300, 32'd400});

        $display("[TB] overflow");
        got_q.delete();
        out_ready_i = 1'b0;
        apply_pass('{32'd3, 32'd5, 32'd7, 32'd9}, 1'b1);
        psum_en_i = 1'b1;
        psum_i    = 32'd99;
        step();
        psum_en_i = 1'b0;
        check_output("ovf_set", 32'(overflow_o), 32'd1);
        out_ready_i = 1'b1;
        wait_idle();
        check_got("ovf", '{32'd3, 32'd5, 32'd7, 32'd9});
        check_output("ovf_sticky", 32'(overflow_o), 32'd1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        check_output("clear_ovf", 32'(overflow_o), 32'd0);

        $display("[TB] clear during drain");
        out_ready_i = 1'b0;
        apply_pass('{32'd2, 32'd4, 32'd6, 32'd8}, 1'b1);
        check_output("cd_pass_cnt", 32'(pass_cnt_o), 32'd1);
        check_output("cd_valid", 32'(out_valid_o), 32'd1);
        clear_i   = 1'b1;
        psum_en_i = 1'b1;
        psum_i    = 32'd55;
        step();
        clear_i   = 1'b0;
        psum_en_i = 1'b0;
        check_all_zero("cd_after");
        out_ready_i = 1'b1;

        $display("[TB] arithmetic");
        got_q.delete();
        apply_pass('{32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0}, 1'b0);
        apply_pass('{32'd1, 32'hFFFFFFFF, 32'd0, 32'd0}, 1'b1);
        wait_idle();
`ifdef PSUM_COLLECTOR_SAT_EN
        exp_arith = '{32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0};
`else
        exp_arith = '{32'h80000000, 32'h7FFFFFFF, 32'd0, 32'd0};
`endif
        check_got("arith", exp_arith);

        $display("[TB] reset mid-accumulate");
        psum_en_i = 1'b1;
        psum_i    = 32'd50;
        step();
        psum_i    = 32'd60;
        step();
        psum_en_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        @(negedge clk);
        #2 rst_n = 1'b1;
        step();
        got_q.delete();
        apply_pass('{32'd5, 32'd6, 32'd7, 32'd8}, 1'b1);
        wait_idle();
        check_got("rst_after", '{32'd5, 32'd6, 32'd7, 32'd8});

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psum_collector.md
# psum_collector

Column-bottom consumer for the systolic PE array: captures the qualified partial-sum stream leaving the last PE of a column (`psum_o`/`psum_en_o`) and accumulates it across K-tile passes in a DEPTH-entry buffer. After the final pass it drains the finished sums through a valid/ready output port. It is the receiving end of the PE psum chain, one instance per array column.

## Interface
- `PSUM_WIDTH`, default 32: width of psum data and of the accumulators.
- `DEPTH`, default 8: psums per pass, equal to the array rows. Must be at least 2.
- `PASS_CNT_WIDTH`, default 4: width of the pass counter.
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `psum_i` input, PSUM_WIDTH bits: psum from the bottom PE, signed two's complement.
- `psum_en_i` input, 1 bit: `psum_i` is valid this cycle.
- `tile_last_i` input, 1 bit: the current pass is the final K tile. Sampled only with the first psum of a pass.
- `clear_i` input, 1 bit: synchronous abort and start of a new output tile.
- `out_data_o` output, PSUM_WIDTH bits: drained result. Reads 0 whenever `out_valid_o` is 0.
- `out_valid_o` output, 1 bit: `out_data_o` is valid.
- `out_ready_i` input, 1 bit: downstream accepts the data.
- `out_last_o` output, 1 bit: marks the final (DEPTH-1) entry of the drain.
- `busy_o` output, 1 bit: high when the state is not IDLE.
- `overflow_o` output, 1 bit, sticky: a psum arrived while the block could not accept it.
- `pass_cnt_o` output, PASS_CNT_WIDTH bits: passes completed since the last tile start. Wraps.

## Operation
- Internal state: buffer `buf[0..DEPTH-1]`, write index `widx`, read index `ridx`, flag `first` (set means write instead of add), latched flag `last_pass`.
- States:
  - **IDLE**: on `psum_en_i`:
    - write `buf[0]`;
    - latch `last_pass` from `tile_last_i`;
    - set `widx` to 1;
    - move to ACCUM.
  - **ACCUM**: on `psum_en_i`, update `buf[widx]` and increment `widx`. Idle cycles (gaps) are allowed and the state holds. When the write at `widx == DEPTH-1` completes:
    - `pass_cnt_o` increments;
    - if `last_pass` is set, go to DRAIN with `ridx` = 0;
    - otherwise go to IDLE with `first` cleared.
  - **DRAIN**: `out_valid_o` is 1 and `out_data_o` shows `buf[ridx]`. `out_last_o` is 1 when `ridx == DEPTH-1`. On each handshake (`out_valid_o & out_ready_i`) `ridx` increments. The last handshake returns to IDLE, sets `first`, and zeroes `pass_cnt_o`.
- Buffer update: when `first` is set, `buf[i]` takes `psum_i`; otherwise `buf[i]` takes `buf[i] + psum_i`. Result width is PSUM_WIDTH.
- A `psum_en_i` in DRAIN is dropped and sets `overflow_o`. The buffer and the drain are unaffected.
- `clear_i` has priority over all other inputs:
  - state goes to IDLE, `widx`/`ridx` to 0, `first` to 1;
  - `overflow_o`, `pass_cnt_o` and `out_valid_o` go to 0;
  - a `psum_en_i` in the same cycle is dropped and does not set overflow.
- Buffer contents are never explicitly cleared; the `first` flag makes any stale data irrelevant.

## Timing
- Reset values: state IDLE, `first` = 1, and every output is 0 (`out_data_o`, `out_valid_o`, `out_last_o`, `busy_o`, `overflow_o`, `pass_cnt_o`).
- Reset mid-operation abandons the pass or drain immediately and asynchronously. No partial output follows.
- Latency: the final psum of the last pass is captured at edge N, and `out_valid_o` is 1 after edge N with `buf[0]`.
- Throughput: one psum per cycle on input. A drain takes DEPTH cycles minimum with `out_ready_i` held high.
- Handshake rules:
  - once asserted, `out_valid_o`, `out_data_o` and `out_last_o` stay stable until accepted;
  - the block does not wait on `out_ready_i` before raising valid.
- Final handshake coincident with `psum_en_i`: the psum is dropped and `overflow_o` is set. The next pass must start on the cycle after `busy_o` falls.
- `busy_o` rises after the edge that captures the first psum and falls after the edge of the last handshake.

## Configuration
- Macro `PSUM_COLLECTOR_SAT_EN`.
  - Defined: accumulation is a signed saturating add, clamped to [-2^(PSUM_WIDTH-1), 2^(PSUM_WIDTH-1)-1].
  - Undefined: accumulation is a two's-complement wrap-around add.
- The first-pass write is unaffected in both modes.

## Test plan
- **Single pass, no backpressure**: DEPTH=4, `tile_last_i`=1, psums 1,2,3,4 back-to-back, ready=1. Required: outputs 1,2,3,4 on four consecutive cycles, `out_last_o` only with 4, valid rising the cycle after 4 is captured, `busy_o` then 0.
- **Two passes**: pass 1 is 10,20,30,40 with last=0, followed by a 2-cycle gap, then pass 2 is 1,2,3,4 with last=1. Required: `pass_cnt_o` reads 1 then 2; output 11,22,33,44.
- **Backpressure**: ready pattern 0,1,0,0,1,1,0,1. Required: data held stable while stalled, all four values delivered once and in order.
- **Overflow**: `psum_en_i` with value 99 during DRAIN. Required: `overflow_o`=1 and drained values unchanged. A subsequent `clear_i` returns `overflow_o`, `pass_cnt_o` and `out_valid_o` to 0.
- **Arithmetic, 32-bit, two passes**:
  - without the macro: 0x7FFFFFFF+1 gives 0x80000000;
  - with `PSUM_COLLECTOR_SAT_EN`: 0x7FFFFFFF+1 gives 0x7FFFFFFF, and 0x80000000+0xFFFFFFFF gives 0x80000000.
- **Reset mid-ACCUM**: assert `rst_n`=0 after two psums. Required: all outputs 0. A following pass of 5,6,7,8 with last=1 drains exactly 5,6,7,8.
